alu_issue_ctrl: RTL
===================

Name: alu_issue_ctrl

Overview:
- Upstream sequencer for TotalALU. Accepts one decoded R-type operation at a time and drives dataA/dataB/Signal into TotalALU.
- Holds those operands stable for the operation's fixed latency, since the multiplier is multi-cycle and ALUControl is registered.
- Captures TotalALU.Output and presents it as a one-cycle write-back.
- Serialises MULTU against MFHI/MFLO so HI/LO reads never see a partial product.

Parameters:
- ALU_LAT, 2, cycles from accept edge to Output valid for AND/OR/ADD/SUB/SLT/SLL/MFHI/MFLO (includes ALUControl register stage)
- MUL_LAT, 33, cycles from accept edge to HiLo holding the MULTU product (32 iterations + HiLo latch)
- CNT_W, 6, width of latency counter; must hold MUL_LAT

Ports:
- clk        in   1   system clock, rising edge
- reset      in   1   asynchronous, active-low reset
- op_valid   in   1   upstream presents an operation
- op_ready   out  1   block can accept an operation this cycle
- op_funct   in   6   MIPS funct code
- op_rs_data in   32  rs operand value
- op_rt_data in   32  rt operand value
- op_shamt   in   5   shift amount (SLL)
- op_rd      in   5   destination register index
- dataA      out  32  to TotalALU.dataA
- dataB      out  32  to TotalALU.dataB
- Signal     out  6   to TotalALU.Signal
- alu_result in   32  from TotalALU.Output
- wb_valid   out  1   one-cycle write-back strobe
- wb_rd      out  5   write-back register index
- wb_data    out  32  write-back value
- mul_done   out  1   one-cycle pulse: HI/LO updated by MULTU
- illegal    out  1   one-cycle pulse: unsupported funct rejected

Behaviour:
- Reset (reset=0, async):
  - state=IDLE, counter=0, op_ready=1.
  - dataA=0, dataB=0, Signal=6'b010010 (MFLO, the neutral read-only code).
  - wb_valid=0, wb_rd=0, wb_data=0, mul_done=0, illegal=0.
  - Reset mid-operation aborts it with no write-back and no pulse; TotalALU shares the reset line.
- States: IDLE, EXEC, DONE.
- IDLE:
  - op_ready=1.
  - On edge E0 with op_valid=1 and a legal funct: latch the operands and rd, load counter with LAT-1, go to EXEC.
  - Illegal funct: illegal=1 for the cycle after E0, stay in IDLE, outputs unchanged.
- Operand mapping, registered at E0:
  - AND/OR/ADD/SUB/SLT/MULTU/MFHI/MFLO: dataA=rs, dataB=rt.
  - SLL: dataA=rt, dataB={27'b0,shamt}.
  - Signal=funct.
- EXEC:
  - op_ready=0; dataA/dataB/Signal held constant; counter decrements each edge.
  - When counter==0, the next edge (E0+LAT) goes to DONE and captures alu_result into wb_data.
  - LAT=ALU_LAT, or MUL_LAT for MULTU.
- DONE (one cycle):
  - Non-MULTU with rd!=0: wb_valid=1.
  - Non-MULTU with rd==0: wb_valid=0, result discarded.
  - MULTU: wb_valid=0, mul_done=1.
  - Signal returns to MFLO, dataA/dataB to 0.
  - op_ready=1, so a new op may be accepted at the DONE edge (back-to-back).
  - Throughput is one op per LAT+1 cycles.
- wb_rd and wb_data hold their values until the next capture. wb_valid, mul_done and illegal are strictly single-cycle.
- op_valid is ignored while op_ready=0; upstream must hold its operation until the handshake completes.
- MFHI/MFLO issued after MULTU always read the completed product, because MULTU blocks until DONE.

Decomposition:
- Package alu_issue_pkg:
  - funct constants AND=36, OR=37, ADD=32, SUB=34, SLT=42, SLL=0, MULTU=25, MFHI=16, MFLO=18
  - state enum
  - neutral Signal constant
  - is_legal/latency-select function
- One natural sub-module: issue_lat_counter, a loadable down-counter with zero flag.

Test Plan:
- Reset then ADD, rs=5, rt=7, rd=3 -> Signal=32 held 2 cycles; wb_valid at E0+2 with wb_rd=3, wb_data=12; op_ready low in between.
- SLL, rt=0x0000_0001, shamt=4, rd=9 -> dataA=1, dataB=4; wb_data=0x0000_0010.
- MULTU rs=0xFFFF_FFFF, rt=2, then MFHI rd=4 held on op_valid -> op_ready low 33 cycles; mul_done pulses, no wb_valid; MFHI accepted at DONE; wb_data=1.
- funct=6'b000011 -> illegal pulses 1 cycle; no wb_valid; op_ready stays 1. SUB with rd=0 -> no wb_valid.
- Assert reset=0 at cycle 10 of MULTU -> all outputs immediately at reset values; no mul_done; next ADD 1+1 gives wb_data=2.
- Back-to-back OR 0xF0|0x0F then SLT 3<5 -> two wb_valid pulses 3 cycles apart; data 0xFF then 1.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared constants, state encoding and decode helpers for the TotalALU issue sequencer.
package alu_issue_pkg;

  localparam int ALU_LAT = 2;
  localparam int MUL_LAT = 33;
  localparam int CNT_W   = 6;

  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;

  // MFLO only reads LO, so parking TotalALU on it between ops disturbs nothing.
  localparam logic [5:0] SIGNAL_NEUTRAL = FN_MFLO;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic isLegal(input logic [5:0] funct);
    case (funct)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT,
      FN_SLL, FN_MULTU, FN_MFHI, FN_MFLO: isLegal = 1'b1;
      default:                            isLegal = 1'b0;
    endcase
  endfunction

  // Counter preload: the EXEC exit happens on the edge after the counter hits zero.
  function automatic logic [CNT_W-1:0] latLoad(input logic [5:0] funct);
    if (funct == FN_MULTU) latLoad = CNT_W'(MUL_LAT - 1);
    else                   latLoad = CNT_W'(ALU_LAT - 1);
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Operation handshake, TotalALU drive/return and write-back signals of the issue sequencer.
interface alu_issue_ctrl_if;

  // Handshake: an operation transfers on a rising edge where op_valid and op_ready are
  // both 1; op_valid is ignored while op_ready is 0 and upstream holds its fields until then.
  logic        op_valid;
  logic        op_ready;
  logic [5:0]  op_funct;
  logic [31:0] op_rs_data;
  logic [31:0] op_rt_data;
  logic [4:0]  op_shamt;
  logic [4:0]  op_rd;

  logic [31:0] dataA;
  logic [31:0] dataB;
  logic [5:0]  Signal;
  logic [31:0] alu_result;

  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        mul_done;
  logic        illegal;

  modport slave (
    input  op_valid, op_funct, op_rs_data, op_rt_data, op_shamt, op_rd, alu_result,
    output op_ready, dataA, dataB, Signal, wb_valid, wb_rd, wb_data, mul_done, illegal
  );

  modport master (
    output op_valid, op_funct, op_rs_data, op_rt_data, op_shamt, op_rd, alu_result,
    input  op_ready, dataA, dataB, Signal, wb_valid, wb_rd, wb_data, mul_done, illegal
  );

endinterface

// File: rtl/alu_issue_ctrl_lat_counter.sv
// Loadable down-counter that stops at zero; zero flag marks the last EXEC cycle.
module issue_lat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] loadVal,
  output logic         zero
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  count <= '0;
    else if (load)               count <= loadVal;
    else if (dec && count != 0)  count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one R-type op to TotalALU, holds its operands for the op latency, then writes back.
module alu_issue_ctrl
  import alu_issue_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  alu_issue_ctrl_if.slave  bus,
  output state_t           dbgState
);

  state_t state, nextState;
  logic   accept, reject, capture, cntZero;
  logic   isMul;
  logic [4:0] rdReg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nextState;
  end

  // DONE accepts like IDLE so back-to-back ops cost LAT+1 cycles.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    reject    = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE, DONE: begin
        nextState = IDLE;
        if (bus.op_valid) begin
          if (isLegal(bus.op_funct)) begin
            accept    = 1'b1;
            nextState = EXEC;
          end else begin
            reject    = 1'b1;
          end
        end
      end
      EXEC: begin
        if (cntZero) begin
          capture   = 1'b1;
          nextState = DONE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  assign bus.op_ready = (state != EXEC);
  assign dbgState     = state;

  issue_lat_counter #(.W(CNT_W)) u_lat (
    .clk     (clk),
    .reset   (reset),
    .load    (accept),
    .dec     (state == EXEC),
    .loadVal (latLoad(bus.op_funct)),
    .zero    (cntZero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bus.dataA    <= '0;
      bus.dataB    <= '0;
      bus.Signal   <= SIGNAL_NEUTRAL;
      bus.wb_valid <= 1'b0;
      bus.wb_rd    <= '0;
      bus.wb_data  <= '0;
      bus.mul_done <= 1'b0;
      bus.illegal  <= 1'b0;
      isMul        <= 1'b0;
      rdReg        <= '0;
    end else begin
      bus.wb_valid <= 1'b0;
      bus.mul_done <= 1'b0;
      bus.illegal  <= reject;
      if (capture) begin
        bus.wb_data  <= bus.alu_result;
        bus.wb_rd    <= rdReg;
        bus.wb_valid <= !isMul && (rdReg != 5'd0);
        bus.mul_done <= isMul;
        bus.dataA    <= '0;
        bus.dataB    <= '0;
        bus.Signal   <= SIGNAL_NEUTRAL;
      end
      if (accept) begin
        // SLL shifts rt by shamt, everything else feeds rs/rt straight through.
        if (bus.op_funct == FN_SLL) begin
          bus.dataA <= bus.op_rt_data;
          bus.dataB <= {27'b0, bus.op_shamt};
        end else begin
          bus.dataA <= bus.op_rs_data;
          bus.dataB <= bus.op_rt_data;
        end
        bus.Signal <= bus.op_funct;
        isMul      <= (bus.op_funct == FN_MULTU);
        rdReg      <= bus.op_rd;
      end
    end
  end

endmodule
